// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared types and constants for the MangoMIPS32 execute stage.
//   alu_op_e    - ALU operation codes carried in the ID/EX register
//   div_state_e - states of the iterative divider
//   DIV_CYCLES  - radix-2 iterations per divide (fixed at 32)
//   abs_val()   - magnitude of a 32-bit operand, signed or unsigned view
package ex_stage_pkg;

    localparam int unsigned DIV_CYCLES = 32;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    typedef enum logic [5:0] {
        ALU_NOP   = 6'd0,  ALU_ADD   = 6'd1,  ALU_ADDU  = 6'd2,  ALU_SUB   = 6'd3,
        ALU_SUBU  = 6'd4,  ALU_AND   = 6'd5,  ALU_OR    = 6'd6,  ALU_XOR   = 6'd7,
        ALU_NOR   = 6'd8,  ALU_SLT   = 6'd9,  ALU_SLTU  = 6'd10, ALU_SLL   = 6'd11,
        ALU_SRL   = 6'd12, ALU_SRA   = 6'd13, ALU_LUI   = 6'd14, ALU_MUL   = 6'd15,
        ALU_JAL   = 6'd16, ALU_JALR  = 6'd17, ALU_MFHI  = 6'd18, ALU_MFLO  = 6'd19,
        ALU_MTHI  = 6'd20, ALU_MTLO  = 6'd21, ALU_MULT  = 6'd22, ALU_MULTU = 6'd23,
        ALU_MADD  = 6'd24, ALU_MADDU = 6'd25, ALU_MSUB  = 6'd26, ALU_MSUBU = 6'd27,
        ALU_DIV   = 6'd28, ALU_DIVU  = 6'd29
    } alu_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Magnitude of v; a negative value is only negated under the signed view.
    function automatic logic [31:0] abs_val(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs and EX/MEM outputs of the execute stage.
//   master - pipeline side driving the ID/EX register fields and flush
//   slave  - ex_stage side consuming them and returning results/stall/HI/LO
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic        flush;
    logic [31:0] ex_pc;
    alu_op_e     ex_aluop;
    logic [31:0] ex_opr1;
    logic [31:0] ex_opr2;
    logic [31:0] ex_offset;
    logic [4:0]  ex_wraddr;
    logic        ex_wreg;
    logic [31:0] ex_result;
    logic [31:0] ex_memaddr;
    logic [4:0]  ex_wraddr_o;
    logic        ex_wreg_o;
    logic        ex_ovf;
    logic        stallreq;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output flush, ex_pc, ex_aluop, ex_opr1, ex_opr2, ex_offset, ex_wraddr, ex_wreg,
        input  ex_result, ex_memaddr, ex_wraddr_o, ex_wreg_o, ex_ovf, stallreq, hi_o, lo_o
    );

    modport slave (
        input  flush, ex_pc, ex_aluop, ex_opr1, ex_opr2, ex_offset, ex_wraddr, ex_wreg,
        output ex_result, ex_memaddr, ex_wraddr_o, ex_wreg_o, ex_ovf, stallreq, hi_o, lo_o
    );

endinterface

// File: rtl/ex_divider.sv
// ex_divider: iterative restoring divider, one quotient bit per cycle.
//   clk, rst             - clock, asynchronous active-low reset
//   start, signed_op     - launch request (DIV/DIVU in EX) and signed view
//   abort                - flush; returns the FSM to IDLE on the next edge
//   dividend, divisor    - operands sampled at launch
//   busy                 - stall request: launch cycle and every BUSY cycle
//   done                 - high in DONE; quotient/remainder valid
//   quotient, remainder  - sign-corrected results (x/0 gives all-ones, x)
module ex_divider
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state_q, state_d, fsm_next_s;
    logic [4:0]  count_q, count_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dsor_q, dsor_d;
    logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, zero_q, zero_d;
    logic [32:0] shifted_s, trial_s;

    // FSM state, iteration counter and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIV_IDLE;
            count_q   <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dsor_q    <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dsor_q    <= dsor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
        end
    end

    // Next-state, shift-subtract step and stall request
    always_comb begin
        fsm_next_s = state_q;
        count_d    = count_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dsor_d     = dsor_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        zero_d     = zero_q;
        busy       = 1'b0;
        // Partial remainder shifted left with the next dividend bit brought in
        shifted_s  = {rem_q, quo_q[31]};
        trial_s    = shifted_s - {1'b0, dsor_q};
        case (state_q)
            DIV_IDLE: begin
                if (start && !abort) begin
                    busy       = 1'b1;
                    fsm_next_s = DIV_BUSY;
                    count_d    = 5'd0;
                    rem_d      = 32'd0;
                    quo_d      = abs_val(dividend, signed_op);
                    dsor_d     = abs_val(divisor, signed_op);
                    neg_quo_d  = signed_op && (dividend[31] ^ divisor[31]);
                    neg_rem_d  = signed_op && dividend[31];
                    zero_d     = (divisor == 32'd0);
                end else begin
                    fsm_next_s = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                busy    = 1'b1;
                count_d = count_q + 5'd1;
                // Borrow out of the trial subtraction means "restore"
                if (!trial_s[32]) begin
                    rem_d = trial_s[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted_s[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (count_q == 5'(DIV_CYCLES - 1)) begin
                    fsm_next_s = DIV_DONE;
                end else begin
                    fsm_next_s = DIV_BUSY;
                end
            end
            DIV_DONE: fsm_next_s = DIV_IDLE;
            default:  fsm_next_s = DIV_IDLE;
        endcase
        state_d = abort ? DIV_IDLE : fsm_next_s;
    end

    // Sign fix-up; a zero divisor still yields |x| as remainder, which
    // the fix-up turns back into the original dividend.
    always_comb begin
        done      = (state_q == DIV_DONE);
        quotient  = zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? (32'd0 - quo_q) : quo_q);
        remainder = neg_rem_q ? (32'd0 - rem_q) : rem_q;
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the MangoMIPS32 pipeline.
//   clk, rst - clock, asynchronous active-low reset
//   bus      - ex_stage_if.slave: ID/EX fields + flush in; result, memaddr,
//              wraddr/wreg pass-through, overflow, stall request, HI/LO out
// Holds the ALU mux, multiplier and HI/LO registers; division is delegated
// to ex_divider. Define EX_MADD_EN to enable MADD/MADDU/MSUB/MSUBU;
// otherwise those opcodes behave as NOP.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);

    logic [31:0] opr1_s, opr2_s, sum_s, diff_s, result_s;
    logic [4:0]  shamt_s;
    logic [63:0] mul_s_s, mul_u_s;
    logic        ovf_s;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        div_start_s, div_busy_s, div_done_s;
    logic [31:0] div_quo_s, div_rem_s;

    assign opr1_s      = bus.ex_opr1;
    assign opr2_s      = bus.ex_opr2;
    assign shamt_s     = opr1_s[4:0];
    assign sum_s       = opr1_s + opr2_s;
    assign diff_s      = opr1_s - opr2_s;
    // Operands widened to 64 bits so the low 64 product bits are exact
    assign mul_s_s     = {{32{opr1_s[31]}}, opr1_s} * {{32{opr2_s[31]}}, opr2_s};
    assign mul_u_s     = {32'd0, opr1_s} * {32'd0, opr2_s};
    assign div_start_s = (bus.ex_aluop == ALU_DIV) || (bus.ex_aluop == ALU_DIVU);

    ex_divider u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_s),
        .signed_op (bus.ex_aluop == ALU_DIV),
        .abort     (bus.flush),
        .dividend  (opr1_s),
        .divisor   (opr2_s),
        .busy      (div_busy_s),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // ALU result mux and signed-overflow detection
    always_comb begin
        result_s = ZERO_WORD;
        ovf_s    = 1'b0;
        case (bus.ex_aluop)
            ALU_ADD: begin
                result_s = sum_s;
                ovf_s    = (opr1_s[31] == opr2_s[31]) && (sum_s[31] != opr1_s[31]);
            end
            ALU_SUB: begin
                result_s = diff_s;
                ovf_s    = (opr1_s[31] != opr2_s[31]) && (diff_s[31] != opr1_s[31]);
            end
            ALU_ADDU: result_s = sum_s;
            ALU_SUBU: result_s = diff_s;
            ALU_AND:  result_s = opr1_s & opr2_s;
            ALU_OR:   result_s = opr1_s | opr2_s;
            ALU_XOR:  result_s = opr1_s ^ opr2_s;
            ALU_NOR:  result_s = ~(opr1_s | opr2_s);
            ALU_SLT:  result_s = {31'd0, $signed(opr1_s) < $signed(opr2_s)};
            ALU_SLTU: result_s = {31'd0, opr1_s < opr2_s};
            ALU_SLL:  result_s = opr2_s << shamt_s;
            ALU_SRL:  result_s = opr2_s >> shamt_s;
            ALU_SRA:  result_s = $unsigned($signed(opr2_s) >>> shamt_s);
            ALU_LUI:  result_s = {opr2_s[15:0], 16'h0000};
            ALU_MUL:  result_s = mul_s_s[31:0];
            ALU_JAL,
            ALU_JALR: result_s = bus.ex_pc + 32'd8;
            ALU_MFHI: result_s = hi_q;
            ALU_MFLO: result_s = lo_q;
            default:  result_s = ZERO_WORD;
        endcase
    end

    // HI/LO next value: flush blocks every write; a finishing divide wins
    // because the stalled DIV is still the opcode in EX during DONE.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (bus.flush) begin
            hi_d = hi_q;
            lo_d = lo_q;
        end else if (div_done_s) begin
            hi_d = div_rem_s;
            lo_d = div_quo_s;
        end else begin
            case (bus.ex_aluop)
                ALU_MTHI:  hi_d = opr1_s;
                ALU_MTLO:  lo_d = opr1_s;
                ALU_MULT:  {hi_d, lo_d} = mul_s_s;
                ALU_MULTU: {hi_d, lo_d} = mul_u_s;
`ifdef EX_MADD_EN
                ALU_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + mul_s_s;
                ALU_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + mul_u_s;
                ALU_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - mul_s_s;
                ALU_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - mul_u_s;
`endif
                default: begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
            endcase
        end
    end

    // HI/LO register pair
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign bus.ex_result   = result_s;
    assign bus.ex_memaddr  = opr1_s + bus.ex_offset;
    assign bus.ex_wraddr_o = bus.ex_wraddr;
    assign bus.ex_wreg_o   = bus.ex_wreg & ~ovf_s;
    assign bus.ex_ovf      = ovf_s;
    assign bus.stallreq    = div_busy_s;
    assign bus.hi_o        = hi_q;
    assign bus.lo_o        = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized scoreboard bench for ex_stage. The driver pushes
// the expected per-cycle response from an arithmetic reference model; a
// negedge monitor pops and compares every field.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_if bus();
    ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          op;
        logic [31:0] result;
        logic        ovf;
        logic        wreg;
        logic [31:0] memaddr;
        logic [4:0]  wraddr;
        logic        stall;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] mhi, mlo;

    localparam longint MAX32 = 64'sd2147483647;
    localparam longint MIN32 = -64'sd2147483648;

    task automatic chk(input string name, input int op, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s op=%0d actual=%h expected=%h t=%0t", name, op, act, exp, $time);
        end
    endtask

    // Monitor: compare the DUT's combinational/registered view mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("result",  mon_e.op, bus.ex_result, mon_e.result);
            chk("ovf",     mon_e.op, {31'd0, bus.ex_ovf}, {31'd0, mon_e.ovf});
            chk("wreg_o",  mon_e.op, {31'd0, bus.ex_wreg_o}, {31'd0, mon_e.wreg});
            chk("memaddr", mon_e.op, bus.ex_memaddr, mon_e.memaddr);
            chk("wraddr",  mon_e.op, {27'd0, bus.ex_wraddr_o}, {27'd0, mon_e.wraddr});
            chk("stall",   mon_e.op, {31'd0, bus.stallreq}, {31'd0, mon_e.stall});
            chk("hi",      mon_e.op, bus.hi_o, mon_e.hi);
            chk("lo",      mon_e.op, bus.lo_o, mon_e.lo);
        end
    end

    function automatic logic [31:0] rnd_opr();
        case ($urandom_range(0, 7))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Drive one cycle and push the reference model's expectation
    task automatic drive(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl = 1'b0, input logic stall_exp = 1'b0, input logic rst_v = 1'b1);
        exp_t             e;
        longint           sa, sb, s;
        longint unsigned  pu;
        logic [63:0]      acc;
        logic [31:0]      pc, off;
        logic [4:0]       wa;
        logic             wr;
        pc  = $urandom;
        off = $urandom;
        wa  = 5'($urandom);
        wr  = 1'($urandom);
        @(posedge clk);
        #1;
        rst = rst_v;
        bus.flush = fl;
        bus.ex_aluop = op;
        bus.ex_opr1 = a;
        bus.ex_opr2 = b;
        bus.ex_pc = pc;
        bus.ex_offset = off;
        bus.ex_wraddr = wa;
        bus.ex_wreg = wr;
        if (!rst_v) begin
            mhi = 32'd0;
            mlo = 32'd0;
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        pu = {32'd0, a} * {32'd0, b};
        e.op = int'(op);
        e.result = 32'd0;
        e.ovf = 1'b0;
        e.memaddr = a + off;
        e.wraddr = wa;
        e.stall = stall_exp;
        e.hi = mhi;
        e.lo = mlo;
        case (op)
            ALU_ADD:  begin s = sa + sb; e.result = a + b; e.ovf = (s > MAX32) || (s < MIN32); end
            ALU_SUB:  begin s = sa - sb; e.result = a - b; e.ovf = (s > MAX32) || (s < MIN32); end
            ALU_ADDU: e.result = a + b;
            ALU_SUBU: e.result = a - b;
            ALU_AND:  e.result = a & b;
            ALU_OR:   e.result = a | b;
            ALU_XOR:  e.result = a ^ b;
            ALU_NOR:  e.result = ~(a | b);
            ALU_SLT:  e.result = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: e.result = (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  e.result = b << a[4:0];
            ALU_SRL:  e.result = b >> a[4:0];
            ALU_SRA:  e.result = 32'(sb >>> a[4:0]);
            ALU_LUI:  e.result = b * 32'd65536;
            ALU_MUL:  e.result = 32'(sa * sb);
            ALU_JAL, ALU_JALR: e.result = pc + 32'd8;
            ALU_MFHI: e.result = mhi;
            ALU_MFLO: e.result = mlo;
            default:  e.result = 32'd0;
        endcase
        e.wreg = wr & ~e.ovf;
        sb_q.push_back(e);
        acc = {mhi, mlo};
        if (rst_v && !fl) begin
            case (op)
                ALU_MTHI:  mhi = a;
                ALU_MTLO:  mlo = a;
                ALU_MULT:  {mhi, mlo} = sa * sb;
                ALU_MULTU: {mhi, mlo} = pu;
`ifdef EX_MADD_EN
                ALU_MADD:  {mhi, mlo} = acc + sa * sb;
                ALU_MADDU: {mhi, mlo} = acc + pu;
                ALU_MSUB:  {mhi, mlo} = acc - sa * sb;
                ALU_MSUBU: {mhi, mlo} = acc - pu;
`endif
                default: ;
            endcase
        end
    endtask

    task automatic model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint q, r;
        if (b == 32'd0) begin
            mlo = 32'hFFFF_FFFF;
            mhi = a;
        end else if (sgn) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            mlo = 32'(q);
            mhi = 32'(r);
        end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
            mlo = 32'(q);
            mhi = 32'(r);
        end
    endtask

    // abort_kind: 0 none, 1 flush at busy cycle abort_at, 2 reset at abort_at
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int abort_kind, input int abort_at);
        alu_op_e op;
        op = sgn ? ALU_DIV : ALU_DIVU;
        drive(op, a, b, 1'b0, 1'b1);
        for (int k = 0; k < int'(DIV_CYCLES); k++) begin
            if (abort_kind == 1 && k == abort_at) begin
                drive(op, a, b, 1'b1, 1'b1);
                drive(ALU_NOP, a, b, 1'b0, 1'b0);
                return;
            end
            if (abort_kind == 2 && k == abort_at) begin
                drive(ALU_NOP, a, b, 1'b0, 1'b0, 1'b0);
                return;
            end
            drive(op, a, b, 1'b0, 1'b1);
        end
        drive(op, a, b, 1'b0, 1'b0);
        model_div(sgn, a, b);
    endtask

    initial begin
        alu_op_e op;
        rst = 1'b0;
        bus.flush = 1'b0;
        bus.ex_aluop = ALU_NOP;
        bus.ex_opr1 = 32'd0;
        bus.ex_opr2 = 32'd0;
        bus.ex_pc = 32'd0;
        bus.ex_offset = 32'd0;
        bus.ex_wraddr = 5'd0;
        bus.ex_wreg = 1'b0;
        mhi = 32'd0;
        mlo = 32'd0;

        // Reset state
        drive(ALU_NOP, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0);
        drive(ALU_NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Overflow corners
        drive(ALU_ADD,  32'h7FFF_FFFF, 32'd1);
        drive(ALU_ADDU, 32'h7FFF_FFFF, 32'd1);
        drive(ALU_SUB,  32'h8000_0000, 32'd1);
        drive(ALU_SUB,  32'h0000_0005, 32'd7);

        // Multiplies
        drive(ALU_MULT,  32'hFFFF_FFFE, 32'd3);
        drive(ALU_MULTU, 32'hFFFF_FFFE, 32'd3);
        drive(ALU_MFHI,  32'd0, 32'd0);

        // Signed divide -7/2, then MFLO
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
        drive(ALU_MFLO, 32'd0, 32'd0);

        // Unsigned divide by zero
        do_div(1'b0, 32'd10, 32'd0, 0, 0);
        drive(ALU_MFHI, 32'd0, 32'd0);

        // Flush at busy cycle 5 keeps prior HI/LO
        drive(ALU_MTHI, 32'h1234_5678, 32'd0);
        drive(ALU_MTLO, 32'h9ABC_DEF0, 32'd0);
        do_div(1'b1, 32'd100, 32'd7, 1, 5);
        drive(ALU_MFLO, 32'd0, 32'd0);

        // Flushed MULT does not touch HI/LO
        drive(ALU_MULT, 32'd9, 32'd9, 1'b1);

        // Multiply-accumulate
        drive(ALU_MTHI, 32'd0, 32'd0);
        drive(ALU_MTLO, 32'd5, 32'd0);
        drive(ALU_MADD, 32'd2, 32'd3);
        drive(ALU_MFLO, 32'd0, 32'd0);

        // Reset in the middle of a divide
        do_div(1'b1, 32'd1000, 32'd3, 2, 3);
        drive(ALU_NOP, 32'd0, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 14) == 0) begin
                do_div(1'($urandom), rnd_opr(), rnd_opr(),
                       ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 31)));
            end else begin
                op = alu_op_e'(6'($urandom_range(0, int'(ALU_MSUBU))));
                drive(op, rnd_opr(), rnd_opr(), ($urandom_range(0, 9) == 0));
            end
        end
        drive(ALU_NOP, 32'd0, 32'd0);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
